// File: rtl/aes_round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_seq_pkg
// Brief    : Shared types and constants for the AES round sequencer slice.
// Revision : 1.0
// ============================================================================
package aes_seq_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam int AES192_ROUNDS = 12;
  localparam int AES256_ROUNDS = 14;
  localparam int AES_BLK_W     = 128;
  localparam int RND_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : aes_round_sequencer_if
// Brief     : Plaintext-in / ciphertext-out valid/ready handshake bundle.
// Revision  : 1.0
// ============================================================================
interface aes_round_sequencer_if;
  import aes_seq_pkg::*;

  logic                 din_valid;
  logic                 din_ready;
  logic [AES_BLK_W-1:0] din;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [AES_BLK_W-1:0] dout;

  modport master (
    output din_valid, din, dout_ready,
    input  din_ready, dout_valid, dout
  );

  modport slave (
    input  din_valid, din, dout_ready,
    output din_ready, dout_valid, dout
  );

endinterface
`default_nettype wire

// File: rtl/aes_rk_regfile.sv
`default_nettype none
// ============================================================================
// Module   : aes_rk_regfile
// Brief    : Round-key store, one write port, async read on the round index.
// Revision : 1.0
// ============================================================================
module aes_rk_regfile
  import aes_seq_pkg::*;
#(
  parameter int ROUND_MAX = AES128_ROUNDS
) (
  input  wire logic                 clk,
  input  wire logic                 i_wr_en,
  input  wire logic [RND_W-1:0]     i_wr_addr,
  input  wire logic [AES_BLK_W-1:0] i_wr_data,
  input  wire logic [RND_W-1:0]     i_rd_addr,
  output logic      [AES_BLK_W-1:0] o_rd_data,
  output logic      [AES_BLK_W-1:0] o_rd0_data
);

  localparam logic [RND_W-1:0] c_ROUND_MAX = RND_W'(ROUND_MAX);

  // Deliberately not reset: keys survive a reset of the sequencer.
  logic [AES_BLK_W-1:0] r_rk [0:ROUND_MAX];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_rk[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data  = (i_rd_addr <= c_ROUND_MAX) ? r_rk[i_rd_addr] : '0;
  assign o_rd0_data = r_rk[0];

endmodule
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer
// Brief    : Control FSM for the iterative AES round datapath with SCA trigger.
// Revision : 1.0
// ============================================================================
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int ROUND_MAX = AES128_ROUNDS
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  aes_round_sequencer_if.slave      bus,
  input  wire logic                 rk_wr_en,
  input  wire logic [RND_W-1:0]     rk_wr_addr,
  input  wire logic [AES_BLK_W-1:0] rk_wr_data,
  output logic                      rk_err,
  output logic                      busy,
  output logic                      trigger,
  output logic                      dp_load1,
  output logic                      dp_load2,
  output logic      [RND_W-1:0]     dp_round1,
  output logic      [RND_W-1:0]     dp_round2,
  output logic      [RND_W-1:0]     dp_round_max,
  output logic      [AES_BLK_W-1:0] dp_key1,
  output logic      [AES_BLK_W-1:0] dp_key2,
  output logic      [AES_BLK_W-1:0] dp_data_i,
  input  wire logic [AES_BLK_W-1:0] dp_data_o
);

  localparam logic [RND_W-1:0] c_ROUND_MAX = RND_W'(ROUND_MAX);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [RND_W-1:0] r_rnd;
  logic [RND_W-1:0] w_rnd_nxt;
  logic             r_rk_err;
  logic             w_rk_wr_ok;
  logic             w_rk_we;
  logic             w_din_ready;
  logic             w_dout_valid;
  logic             w_busy;
  logic             w_accept;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rnd    <= '0;
      r_rk_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rnd    <= w_rnd_nxt;
      r_rk_err <= r_rk_err | (rk_wr_en & ~w_rk_wr_ok);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    case (r_state)
      ST_IDLE: begin
        if (bus.din_valid) begin
          w_state_nxt = ST_RUN;
          w_rnd_nxt   = 4'd1;
        end
      end
      ST_RUN: begin
        if (r_rnd == c_ROUND_MAX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_rnd_nxt = r_rnd + 4'd1;
        end
      end
      ST_DONE: begin
        // Consuming the result and accepting the next block share one edge.
        if (bus.dout_ready) begin
          if (bus.din_valid) begin
            w_state_nxt = ST_RUN;
            w_rnd_nxt   = 4'd1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_din_ready  = 1'b0;
    w_dout_valid = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: w_din_ready = 1'b1;
      ST_RUN:  w_busy      = 1'b1;
      ST_DONE: begin
        w_dout_valid = 1'b1;
        w_din_ready  = bus.dout_ready;
      end
      default: w_din_ready = 1'b0;
    endcase
    w_accept = bus.din_valid & w_din_ready;
  end

  assign w_rk_wr_ok = (r_state != ST_RUN) && (rk_wr_addr <= c_ROUND_MAX);
  assign w_rk_we    = rk_wr_en & w_rk_wr_ok;

  aes_rk_regfile #(
    .ROUND_MAX (ROUND_MAX)
  ) u_rk_regfile (
    .clk        (clk),
    .i_wr_en    (w_rk_we),
    .i_wr_addr  (rk_wr_addr),
    .i_wr_data  (rk_wr_data),
    .i_rd_addr  (r_rnd),
    .o_rd_data  (dp_key2),
    .o_rd0_data (dp_key1)
  );

  assign bus.din_ready  = w_din_ready;
  assign bus.dout_valid = w_dout_valid;
  assign bus.dout       = dp_data_o;

  assign rk_err       = r_rk_err;
  assign busy         = w_busy;
  assign trigger      = w_accept | w_busy;
  assign dp_load1     = w_accept;
  assign dp_load2     = w_busy;
  assign dp_round1    = '0;
  assign dp_round2    = r_rnd;
  assign dp_round_max = c_ROUND_MAX;
  assign dp_data_i    = bus.din;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_sequencer
// Brief    : Directed + random bench with a behavioural AES-128 round datapath.
// Revision : 1.0
// ============================================================================
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         rk_wr_en;
  logic [3:0]   rk_wr_addr;
  logic [127:0] rk_wr_data;
  logic         rk_err, busy, trigger, dp_load1, dp_load2;
  logic [3:0]   dp_round1, dp_round2, dp_round_max;
  logic [127:0] dp_key1, dp_key2, dp_data_i;
  logic [127:0] dp_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb  [0:255];
  logic [127:0] rks [0:10];

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [5];

  aes_round_sequencer_if bus ();

  aes_round_sequencer #(.ROUND_MAX(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .rk_wr_en     (rk_wr_en),
    .rk_wr_addr   (rk_wr_addr),
    .rk_wr_data   (rk_wr_data),
    .rk_err       (rk_err),
    .busy         (busy),
    .trigger      (trigger),
    .dp_load1     (dp_load1),
    .dp_load2     (dp_load2),
    .dp_round1    (dp_round1),
    .dp_round2    (dp_round2),
    .dp_round_max (dp_round_max),
    .dp_key1      (dp_key1),
    .dp_key2      (dp_key2),
    .dp_data_i    (dp_data_i),
    .dp_data_o    (dp_state)
  );

  always #5 clk = ~clk;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic void init_sbox();
    logic [7:0] r, base, v;
    logic [7:0] e;
    e = 8'd254;
    for (int i = 0; i < 256; i++) begin
      v    = 8'(i);
      r    = 8'h01;
      base = v;
      for (int b = 0; b < 8; b++) begin
        if (e[b]) r = gmul(r, base);
        base = gmul(base, base);
      end
      if (v == 8'h00) r = 8'h00;
      sb[i] = r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[c*4+r] = a[((c+r)%4)*4+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[c*4]; x1 = b[c*4+1]; x2 = b[c*4+2]; x3 = b[c*4+3];
        b[c*4]   = gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3;
        b[c*4+1] = x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3;
        b[c*4+2] = x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03);
        b[c*4+3] = gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic void expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rks[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, rks[r], r == 10);
    return s;
  endfunction

  // Behavioural stand-in for the aes_two_rounds datapath
  always @(posedge clk) begin
    if (dp_load1) dp_state <= dp_data_i ^ dp_key1;
    else if (dp_load2) dp_state <= aes_round(dp_state, dp_key2, dp_round2 == dp_round_max);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic checkb(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", nm, act, exp);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    checkb("load_excl", dp_load1 & dp_load2, 1'b0);
    if (dp_load2) checkb("round2_range", (dp_round2 >= 4'd1) && (dp_round2 <= 4'd10), 1'b1);
  endtask

  task automatic write_keys();
    for (int r = 0; r <= 10; r++) begin
      rk_wr_en   = 1'b1;
      rk_wr_addr = 4'(r);
      rk_wr_data = rks[r];
      next_cycle();
    end
    rk_wr_en = 1'b0;
  endtask

  // Starts just after an accept edge; stops at the sample point of the first dout_valid cycle.
  task automatic wait_dout(input int wr_cyc, input logic [3:0] wr_addr,
                           output int lat, output int trig);
    logic got;
    got  = 1'b0;
    lat  = 0;
    trig = 0;
    while (!got && lat < 40) begin
      lat++;
      rk_wr_en   = (lat == wr_cyc);
      rk_wr_addr = wr_addr;
      rk_wr_data = ~rks[wr_addr];
      sample();
      if (bus.dout_valid) got = 1'b1;
      else begin
        if (trigger) trig++;
        next_cycle();
      end
    end
    rk_wr_en = 1'b0;
    if (!got) lat = 999;
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp, input string nm,
                           input int wr_cyc, input logic [3:0] wr_addr);
    int lat, trig;
    bus.din        = pt;
    bus.din_valid  = 1'b1;
    bus.dout_ready = 1'b1;
    rk_wr_en       = (wr_cyc == 0);
    rk_wr_addr     = wr_addr;
    rk_wr_data     = ~rks[wr_addr];
    sample();
    checkb({nm, "_acc_ready"}, bus.din_ready, 1'b1);
    checkb({nm, "_acc_load1"}, dp_load1, 1'b1);
    check({nm, "_key1"}, dp_key1, rks[0]);
    next_cycle();
    bus.din_valid = 1'b0;
    rk_wr_en      = 1'b0;
    wait_dout(wr_cyc, wr_addr, lat, trig);
    checki({nm, "_latency"}, lat, 11);
    checki({nm, "_trigger_cycles"}, trig + 1, 11);
    checkb({nm, "_trigger_done"}, trigger, 1'b0);
    check({nm, "_ct"}, bus.dout, exp);
    next_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           lat, trig;
    logic         seen;
    logic [127:0] key, pt, exp, ct;
    logic         got;
    int           n;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                128'hf5d3d58503b9699de785895a96fdbaaf};
    vecs[4] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    init_sbox();
    reset          = 1'b1;
    rk_wr_en       = 1'b0;
    rk_wr_addr     = 4'd0;
    rk_wr_data     = '0;
    bus.din_valid  = 1'b0;
    bus.din        = '0;
    bus.dout_ready = 1'b0;
    repeat (3) next_cycle();
    reset = 1'b0;

    // Reset state
    sample();
    checkb("rst_din_ready", bus.din_ready, 1'b1);
    checkb("rst_dout_valid", bus.dout_valid, 1'b0);
    checkb("rst_busy", busy, 1'b0);
    checkb("rst_trigger", trigger, 1'b0);
    checkb("rst_load1", dp_load1, 1'b0);
    checkb("rst_load2", dp_load2, 1'b0);
    checkb("rst_rk_err", rk_err, 1'b0);
    check("rst_round1", 128'(dp_round1), 128'd0);
    check("rst_round_max", 128'(dp_round_max), 128'd10);
    next_cycle();

    // Known-answer vectors
    for (int v = 0; v < 5; v++) begin
      expand_key(vecs[v].key);
      write_keys();
      checkb($sformatf("vec%0d_rk_err", v), rk_err, 1'b0);
      run_block(vecs[v].pt, vecs[v].ct, $sformatf("vec%0d", v), -1, 4'd0);
    end

    // rk[0] rewritten on the accept cycle: current block still sees the old key
    expand_key(vecs[0].key);
    write_keys();
    run_block(vecs[0].pt, vecs[0].ct, "acc_wr_rk0", 0, 4'd0);
    checkb("acc_wr_rk_err", rk_err, 1'b0);
    write_keys();

    // Backpressure, held output, back-to-back accept
    expand_key(vecs[2].key);
    write_keys();
    bus.din        = vecs[2].pt;
    bus.din_valid  = 1'b1;
    bus.dout_ready = 1'b0;
    sample();
    next_cycle();
    bus.din_valid = 1'b0;
    wait_dout(-1, 4'd0, lat, trig);
    checki("bp_latency", lat, 11);
    check("bp_ct_a", bus.dout, vecs[2].ct);
    for (int h = 1; h <= 5; h++) begin
      next_cycle();
      bus.din       = vecs[3].pt;
      bus.din_valid = 1'b1;
      sample();
      check($sformatf("bp_hold%0d_dout", h), bus.dout, vecs[2].ct);
      checkb($sformatf("bp_hold%0d_valid", h), bus.dout_valid, 1'b1);
      checkb($sformatf("bp_hold%0d_din_ready", h), bus.din_ready, 1'b0);
      checkb($sformatf("bp_hold%0d_load1", h), dp_load1, 1'b0);
    end
    next_cycle();
    bus.dout_ready = 1'b1;
    sample();
    checkb("b2b_din_ready", bus.din_ready, 1'b1);
    checkb("b2b_load1", dp_load1, 1'b1);
    checkb("b2b_trigger", trigger, 1'b1);
    check("b2b_dout_at_handoff", bus.dout, vecs[2].ct);
    next_cycle();
    bus.din_valid = 1'b0;
    wait_dout(-1, 4'd0, lat, trig);
    checki("b2b_latency", lat, 11);
    check("b2b_ct_b", bus.dout, vecs[3].ct);
    next_cycle();

    // Round-key write errors
    expand_key(vecs[0].key);
    write_keys();
    run_block(vecs[0].pt, vecs[0].ct, "run_wr", 3, 4'd10);
    checkb("run_wr_rk_err", rk_err, 1'b1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    checkb("rk_err_cleared", rk_err, 1'b0);
    rk_wr_en   = 1'b1;
    rk_wr_addr = 4'd11;
    rk_wr_data = '1;
    next_cycle();
    rk_wr_en = 1'b0;
    checkb("addr11_rk_err", rk_err, 1'b1);
    next_cycle();
    checkb("rk_err_sticky", rk_err, 1'b1);
    run_block(vecs[0].pt, vecs[0].ct, "after_err", -1, 4'd0);
    checkb("after_err_rk_err", rk_err, 1'b1);

    // Reset at RUN cycle 5
    bus.din        = vecs[0].pt;
    bus.din_valid  = 1'b1;
    bus.dout_ready = 1'b1;
    sample();
    next_cycle();
    bus.din_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      sample();
      next_cycle();
    end
    reset = 1'b1;
    sample();
    checkb("mid_busy", busy, 1'b1);
    check("mid_round2", 128'(dp_round2), 128'd5);
    next_cycle();
    reset = 1'b0;
    sample();
    checkb("abort_din_ready", bus.din_ready, 1'b1);
    checkb("abort_dout_valid", bus.dout_valid, 1'b0);
    checkb("abort_busy", busy, 1'b0);
    checkb("abort_rk_err", rk_err, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      next_cycle();
      sample();
      if (bus.dout_valid) seen = 1'b1;
    end
    checkb("abort_no_valid", seen, 1'b0);
    next_cycle();
    run_block(vecs[0].pt, vecs[0].ct, "post_abort", -1, 4'd0);

    // Random sweep with random gaps and backpressure
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key);
      exp = aes_enc(pt);
      write_keys();
      repeat ($urandom_range(0, 2)) next_cycle();
      bus.din        = pt;
      bus.din_valid  = 1'b1;
      bus.dout_ready = 1'b0;
      sample();
      next_cycle();
      bus.din_valid = 1'b0;
      got = 1'b0;
      ct  = '0;
      n   = 0;
      while (!got && n < 60) begin
        bus.dout_ready = 1'($urandom_range(0, 1));
        sample();
        if (bus.dout_valid && bus.dout_ready) begin
          got = 1'b1;
          ct  = bus.dout;
        end
        n++;
        next_cycle();
      end
      check($sformatf("sweep%0d", i), ct, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
